// File: rtl/muldiv_seq_if.sv
// Request/response and borrowed-ALU signals between the execute stage and muldiv_seq.
interface muldiv_seq_if;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_kill;
    logic        o_alu_busy;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [3:0]  o_alu_control;
    logic [31:0] i_alu_result;
    logic [3:0]  i_alu_flags;
    logic        o_done;
    logic [31:0] o_result;

    modport slave (
        input  i_valid, i_op, i_rs1, i_rs2, i_kill, i_alu_result, i_alu_flags,
        output o_ready, o_alu_busy, o_alu_a, o_alu_b, o_alu_control, o_done, o_result
    );

    modport master (
        output i_valid, i_op, i_rs1, i_rs2, i_kill, i_alu_result, i_alu_flags,
        input  o_ready, o_alu_busy, o_alu_a, o_alu_b, o_alu_control, o_done, o_result
    );
endinterface

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: 32 shift-add / restoring-divide steps on the shared ALU,
// sign handling and divide special cases kept local.
module muldiv_seq (
    input  logic        i_clk,
    input  logic        i_rst,
    muldiv_seq_if.slave bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   hi;      // multiply: product high / divide: remainder
    logic [XLEN-1:0]   lo;      // multiply: product low  / divide: quotient
    logic [XLEN-1:0]   bmag;
    logic              neg_res;
    logic              neg_rem;

    // Accept-time operand decode
    logic              a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, sc_result, init_a, init_b;

    always_comb begin
        a_sgn     = (bus.i_op == 3'b001) || (bus.i_op == 3'b010) ||
                    (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        b_sgn     = (bus.i_op == 3'b001) || (bus.i_op == 3'b100) || (bus.i_op == 3'b110);
        a_neg     = a_sgn && bus.i_rs1[XLEN-1];
        b_neg     = b_sgn && bus.i_rs2[XLEN-1];
        a_mag     = a_neg ? (~bus.i_rs1 + XLEN'(1)) : bus.i_rs1;
        b_mag     = b_neg ? (~bus.i_rs2 + XLEN'(1)) : bus.i_rs2;
        div_zero  = bus.i_op[2] && (bus.i_rs2 == '0);
        div_ovf   = bus.i_op[2] && !bus.i_op[0] &&
                    (bus.i_rs1 == 32'h8000_0000) && (bus.i_rs2 == 32'hFFFF_FFFF);
        sc_result = '0;
        if (div_zero) begin
            sc_result = bus.i_op[1] ? bus.i_rs1 : 32'hFFFF_FFFF;
        end else if (!bus.i_op[1]) begin
            sc_result = 32'h8000_0000;
        end
        // First-iteration operands: hi and r both start at zero
        if (bus.i_op[2]) begin
            init_a = {{(XLEN-1){1'b0}}, a_mag[XLEN-1]};
            init_b = b_mag;
        end else begin
            init_a = '0;
            init_b = a_mag[0] ? b_mag : '0;
        end
    end

    // One iteration step from the ALU return, plus operands for the following step
    logic              carry, ok;
    logic [XLEN-1:0]   div_s, nhi, nlo, na, nb;
    logic              unused_flags;

    assign carry        = bus.i_alu_flags[2];
    assign unused_flags = ^{bus.i_alu_flags[3], bus.i_alu_flags[1:0]};

    always_comb begin
        div_s = {hi[XLEN-2:0], lo[XLEN-1]};
        ok    = hi[XLEN-1] | ~carry;   // r[31] set means the 33-bit partial remainder exceeds any divisor
        if (!op[2]) begin
            nhi = {carry, bus.i_alu_result[XLEN-1:1]};
            nlo = {bus.i_alu_result[0], lo[XLEN-1:1]};
            na  = nhi;
            nb  = nlo[0] ? bmag : '0;
        end else begin
            nhi = ok ? bus.i_alu_result : div_s;
            nlo = {lo[XLEN-2:0], ok};
            na  = {nhi[XLEN-2:0], nlo[XLEN-1]};
            nb  = bmag;
        end
    end

    // Sign fix-up and output word selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, fix_result;

    always_comb begin
        prod_fix = neg_res ? (~{hi, lo} + (2*XLEN)'(1)) : {hi, lo};
        q_fix    = neg_res ? (~lo + XLEN'(1)) : lo;
        r_fix    = neg_rem ? (~hi + XLEN'(1)) : hi;
        case (op)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = q_fix;
            default:                fix_result = r_fix;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state             <= IDLE;
            cnt               <= '0;
            op                <= '0;
            hi                <= '0;
            lo                <= '0;
            bmag              <= '0;
            neg_res           <= 1'b0;
            neg_rem           <= 1'b0;
            bus.o_ready       <= 1'b1;
            bus.o_done        <= 1'b0;
            bus.o_alu_busy    <= 1'b0;
            bus.o_result      <= '0;
            bus.o_alu_a       <= '0;
            bus.o_alu_b       <= '0;
            bus.o_alu_control <= ALU_ADD;
        end else if (bus.i_kill && (state != IDLE)) begin
            state             <= IDLE;
            bus.o_ready       <= 1'b1;
            bus.o_done        <= 1'b0;
            bus.o_alu_busy    <= 1'b0;
            bus.o_alu_a       <= '0;
            bus.o_alu_b       <= '0;
            bus.o_alu_control <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid && !bus.i_kill) begin
                        op          <= bus.i_op;
                        cnt         <= '0;
                        bmag        <= b_mag;
                        neg_res     <= a_neg ^ b_neg;
                        neg_rem     <= a_neg;
                        hi          <= '0;
                        lo          <= a_mag;
                        bus.o_ready <= 1'b0;
                        if (div_zero || div_ovf) begin
                            state        <= DONE;
                            bus.o_done   <= 1'b1;
                            bus.o_result <= sc_result;
                        end else begin
                            state             <= CALC;
                            bus.o_alu_busy    <= 1'b1;
                            bus.o_alu_a       <= init_a;
                            bus.o_alu_b       <= init_b;
                            bus.o_alu_control <= bus.i_op[2] ? ALU_SUB : ALU_ADD;
                        end
                    end
                end
                CALC: begin
                    hi <= nhi;
                    lo <= nlo;
                    if (cnt == LAST_ITER) begin
                        state             <= FIX;
                        bus.o_alu_busy    <= 1'b0;
                        bus.o_alu_a       <= '0;
                        bus.o_alu_b       <= '0;
                        bus.o_alu_control <= ALU_ADD;
                    end else begin
                        cnt         <= cnt + CNT_W'(1);
                        bus.o_alu_a <= na;
                        bus.o_alu_b <= nb;
                    end
                end
                FIX: begin
                    state        <= DONE;
                    bus.o_done   <= 1'b1;
                    bus.o_result <= fix_result;
                end
                DONE: begin
                    state       <= IDLE;
                    bus.o_done  <= 1'b0;
                    bus.o_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table through a result scoreboard plus
// hand-written kill, reset and held-valid sequences.
module tb_muldiv_seq;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    muldiv_seq_if bus ();

    muldiv_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: add reports carry-out, subtract reports borrow
    logic [32:0] alu_sum;
    logic        alu_carry;
    always_comb begin
        if (bus.o_alu_control == 4'b0001) begin
            alu_sum   = {1'b0, bus.o_alu_a} - {1'b0, bus.o_alu_b};
            alu_carry = bus.o_alu_a < bus.o_alu_b;
        end else begin
            alu_sum   = {1'b0, bus.o_alu_a} + {1'b0, bus.o_alu_b};
            alu_carry = alu_sum[32];
        end
        bus.i_alu_result = alu_sum[31:0];
        bus.i_alu_flags  = {1'b0, alu_carry, alu_sum[31], alu_sum[31:0] == 32'd0};
    end

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          lat_v = 0;
    int          busy_tot = 0;
    int          ctrl_err_tot = 0;
    int          done_tot = 0;
    int          acc_tot = 0;
    int          done_cyc_last = 0;
    logic [31:0] cur_exp = '0;
    logic [3:0]  exp_ctrl = '0;
    logic [31:0] sb[$];
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called at a negedge: scoreboard the coming edge, advance one cycle, sample at the next negedge
    task automatic tick();
        logic acc;
        acc = bus.i_valid && bus.o_ready && !bus.i_kill && !rst;
        if (rst || (bus.i_kill && !bus.o_ready)) sb.delete();
        if (acc) begin
            sb.push_back(cur_exp);
            acc_cyc = cyc;
            acc_tot++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (bus.o_alu_busy) begin
            busy_tot++;
            if (bus.o_alu_control !== exp_ctrl) ctrl_err_tot++;
        end
        if (bus.o_done) begin
            done_tot++;
            lat_v = cyc - acc_cyc;
            done_cyc_last = cyc;
            if (sb.size() == 0) chk("orphan_done", 32'd1, 32'd0);
            else chk("result", bus.o_result, sb.pop_front());
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_rs1   = a;
        bus.i_rs2   = b;
        cur_exp     = exp;
        exp_ctrl    = {3'b000, op[2]};
    endtask

    task automatic run_vec(input vec_t v);
        int b0, d0, e0;
        b0 = busy_tot;
        d0 = done_tot;
        e0 = ctrl_err_tot;
        chk("ready_before", 32'(bus.o_ready), 32'd1);
        drive(v.op, v.a, v.b, v.exp);
        tick();
        bus.i_valid = 1'b0;
        for (int k = 0; k < 60 && done_tot == d0; k++) tick();
        chk("done_count", 32'(done_tot - d0), 32'd1);
        chk("latency", 32'(lat_v), 32'(v.lat));
        chk("busy_cycles", 32'(busy_tot - b0), (v.lat == 34) ? 32'd32 : 32'd0);
        chk("alu_control", 32'(ctrl_err_tot - e0), 32'd0);
        tick();
        chk("ready_after", 32'(bus.o_ready), 32'd1);
        chk("result_held", bus.o_result, v.exp);
        chk("alu_idle_a", bus.o_alu_a, 32'd0);
    endtask

    initial begin
        int d0, a0, first_done;
        logic [31:0] held;

        vecs.push_back('{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
        vecs.push_back('{OP_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
        vecs.push_back('{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 34});
        vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
        vecs.push_back('{OP_DIV,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         34});
        vecs.push_back('{OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
        vecs.push_back('{OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'd1,         32'h8000_0000, 34});
        vecs.push_back('{OP_DIVU,   32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 34});
        vecs.push_back('{OP_REMU,   32'hFFFF_FFFF,  32'd2,         32'd1,         34});
        vecs.push_back('{OP_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 32'd1,         34});
        vecs.push_back('{OP_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 32'h7FFF_FFFE, 34});
        vecs.push_back('{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REM,    32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{OP_REMU,   32'd5,          32'd0,         32'd5,         1});
        vecs.push_back('{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_kill  = 1'b0;
        bus.i_op    = '0;
        bus.i_rs1   = '0;
        bus.i_rs2   = '0;
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_busy", 32'(bus.o_alu_busy), 32'd0);
        chk("rst_result", bus.o_result, 32'd0);
        chk("rst_alu_b", bus.o_alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(bus.o_alu_control), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Kill in IDLE blocks the accept on the same edge
        drive(OP_MUL, 32'd3, 32'd4, 32'd12);
        bus.i_kill = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        bus.i_kill  = 1'b0;
        chk("kill_idle_ready", 32'(bus.o_ready), 32'd1);
        chk("kill_idle_busy", 32'(bus.o_alu_busy), 32'd0);

        // Kill during CALC cycle 10
        held = bus.o_result;
        d0   = done_tot;
        drive(OP_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        tick();
        bus.i_valid = 1'b0;
        repeat (9) tick();
        chk("kill_c10_busy", 32'(bus.o_alu_busy), 32'd1);
        bus.i_kill = 1'b1;
        tick();
        bus.i_kill = 1'b0;
        chk("kill_ready", 32'(bus.o_ready), 32'd1);
        chk("kill_busy", 32'(bus.o_alu_busy), 32'd0);
        chk("kill_alu_ctrl", 32'(bus.o_alu_control), 32'd0);
        repeat (40) tick();
        chk("kill_no_done", 32'(done_tot - d0), 32'd0);
        chk("kill_result_held", bus.o_result, held);
        run_vec('{OP_MUL, 32'd3, 32'd4, 32'd12, 34});

        // Reset during CALC cycle 5
        d0 = done_tot;
        drive(OP_MUL, 32'd5, 32'd6, 32'd30);
        tick();
        bus.i_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        chk("mid_rst_done", 32'(bus.o_done), 32'd0);
        chk("mid_rst_busy", 32'(bus.o_alu_busy), 32'd0);
        chk("mid_rst_result", bus.o_result, 32'd0);
        chk("mid_rst_alu_a", bus.o_alu_a, 32'd0);
        chk("mid_rst_alu_b", bus.o_alu_b, 32'd0);
        chk("mid_rst_alu_ctrl", 32'(bus.o_alu_control), 32'd0);
        repeat (40) tick();
        chk("mid_rst_no_done", 32'(done_tot - d0), 32'd0);

        // Valid held high while busy: exactly one accept per operation, back-to-back at cycle 35
        d0         = done_tot;
        a0         = acc_tot;
        first_done = 0;
        drive(OP_MUL, 32'd3, 32'd4, 32'd12);
        for (int k = 0; k < 120 && (done_tot - d0) < 2; k++) begin
            tick();
            if (acc_tot - a0 >= 2) bus.i_valid = 1'b0;
            if (first_done == 0 && (done_tot - d0) == 1) first_done = done_cyc_last;
        end
        bus.i_valid = 1'b0;
        chk("held_accepts", 32'(acc_tot - a0), 32'd2);
        chk("held_dones", 32'(done_tot - d0), 32'd2);
        chk("held_done_gap", 32'(done_cyc_last - first_done), 32'd35);
        tick();
        chk("held_final_ready", 32'(bus.o_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
